// File: rtl/gomoku_pkg.sv
// Gomoku shared constants: cell encoding, controller states, board size.
// Used by board_state and pixel_gen.
package gomoku_pkg;

    localparam int BOARD_N_DEF = 15;
    localparam int N_CELLS     = BOARD_N_DEF * BOARD_N_DEF;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/cursor_ctrl.sv
// Board cursor: saturating moves by default, wrapping moves when
// CURSOR_WRAP_EN is defined.
module cursor_ctrl #(
    parameter int BOARD_N = 15,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_left,
    input  logic               i_right,
    input  logic               i_en,
    input  logic               i_new_game,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y
);

    localparam logic [COORD_W-1:0] MAX = COORD_W'(BOARD_N - 1);
    localparam logic [COORD_W-1:0] CTR = COORD_W'(BOARD_N / 2);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    // Opposing pulses on one axis cancel out.
    function automatic logic [COORD_W-1:0] step(
        input logic [COORD_W-1:0] p,
        input logic               inc,
        input logic               dec
    );
        step = p;
`ifdef CURSOR_WRAP_EN
        if (inc && !dec)
            step = (p == MAX) ? '0 : p + 1'b1;
        else if (dec && !inc)
            step = (p == '0) ? MAX : p - 1'b1;
`else
        if (inc && !dec && p != MAX)
            step = p + 1'b1;
        else if (dec && !inc && p != '0)
            step = p - 1'b1;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= CTR;
            r_y <= CTR;
        end else if (i_new_game) begin
            r_x <= CTR;
            r_y <= CTR;
        end else if (i_en) begin
            r_x <= step(r_x, i_right, i_left);
            r_y <= step(r_y, i_down, i_up);
        end
    end

    assign cursor_x = r_x;
    assign cursor_y = r_y;

endmodule

// File: rtl/board_state.sv
// Gomoku board store, cursor and turn controller with registered read port.
// Optional CURSOR_WRAP_EN makes cursor moves wrap at the board edges.
module board_state import gomoku_pkg::*; #(
    parameter int BOARD_N = BOARD_N_DEF,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_place,
    input  logic               new_game,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic [1:0]         rd_cell,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               turn,
    output logic               busy,
    output logic               place_ok,
    output logic               place_err,
    output logic [7:0]         stone_count,
    output logic               board_full
);

    localparam int               CELLS = BOARD_N * BOARD_N;
    localparam int               IDX_W = 8;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(CELLS - 1);
    localparam logic [COORD_W-1:0] EDGE = COORD_W'(BOARD_N);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_board [CELLS];
    logic [IDX_W-1:0] r_clr_idx;
    logic [IDX_W-1:0] r_chk_idx;
    logic             r_turn;
    logic [7:0]       r_count;
    logic             r_ok;
    logic             r_err;
    logic [1:0]       r_rd_cell;

    logic [IDX_W-1:0] w_cur_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [1:0]       w_wr_data;
    logic [1:0]       w_chk_cell;
    logic             w_we;
    logic             w_move_en;
    logic             w_chk_empty;
    logic             w_done;
    logic             w_reject;
    logic             w_rd_ok;

    assign w_cur_idx = IDX_W'(cursor_y) * IDX_W'(BOARD_N)
                     + IDX_W'(cursor_x);
    assign w_rd_idx  = IDX_W'(rd_y) * IDX_W'(BOARD_N)
                     + IDX_W'(rd_x);
    assign w_rd_ok   = (rd_x < EDGE) && (rd_y < EDGE);

    assign w_chk_cell  = r_board[r_chk_idx];
    assign w_chk_empty = (w_chk_cell == CELL_EMPTY);
    assign w_done   = (r_state == ST_CHECK) && w_chk_empty && !new_game;
    assign w_reject = (r_state == ST_CHECK) && !w_chk_empty && !new_game;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_CLEAR;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_clr_idx == LAST) w_next = ST_IDLE;
            ST_IDLE:  if (btn_place) w_next = ST_CHECK;
            ST_CHECK: w_next = ST_IDLE;
            default:  w_next = ST_CLEAR;
        endcase
        if (new_game) w_next = ST_CLEAR;
    end

    always_comb begin
        busy      = 1'b1;
        w_move_en = 1'b0;
        w_we      = 1'b0;
        w_wr_idx  = r_clr_idx;
        w_wr_data = CELL_EMPTY;
        unique case (r_state)
            ST_CLEAR: w_we = 1'b1;
            ST_IDLE: begin
                busy      = 1'b0;
                w_move_en = !new_game && !btn_place;
            end
            ST_CHECK: begin
                w_we      = w_done;
                w_wr_idx  = r_chk_idx;
                w_wr_data = r_turn ? CELL_WHITE : CELL_BLACK;
            end
            default: ;
        endcase
    end

    // Board is fully rewritten by CLEAR after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_we) r_board[w_wr_idx] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr_idx <= '0;
            r_chk_idx <= '0;
            r_turn    <= 1'b0;
            r_count   <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_rd_cell <= CELL_EMPTY;
        end else begin
            r_ok  <= w_done;
            r_err <= w_reject;
            if (r_state == ST_CLEAR && !new_game)
                r_clr_idx <= r_clr_idx + 1'b1;
            else
                r_clr_idx <= '0;
            if (r_state == ST_IDLE && btn_place)
                r_chk_idx <= w_cur_idx;
            if (new_game) begin
                r_turn  <= 1'b0;
                r_count <= '0;
            end else if (w_done) begin
                r_turn  <= ~r_turn;
                r_count <= r_count + 1'b1;
            end
            if (w_rd_ok && r_state != ST_CLEAR)
                r_rd_cell <= r_board[w_rd_idx];
            else
                r_rd_cell <= CELL_EMPTY;
        end
    end

    cursor_ctrl #(
        .BOARD_N (BOARD_N),
        .COORD_W (COORD_W)
    ) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .i_up       (btn_up),
        .i_down     (btn_down),
        .i_left     (btn_left),
        .i_right    (btn_right),
        .i_en       (w_move_en),
        .i_new_game (new_game),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    assign rd_cell     = r_rd_cell;
    assign turn        = r_turn;
    assign place_ok    = r_ok;
    assign place_err   = r_err;
    assign stone_count = r_count;
    assign board_full  = (r_count == 8'(CELLS));

endmodule

// File: doc/board_state.md
Name: board_state

Overview:
- Gomoku board store and move controller, one stage upstream of pixel_gen.
- Holds the board, the cursor and whose turn it is; applies debounced button pulses.
- Exposes a registered random-access read port that pixel_gen pipelines against the h_cnt/v_cnt from VgaCtrl.
- Runs in the 25 MHz pixel clock domain.

Parameters:
- BOARD_N, 15, board edge length in cells (coordinates 0..BOARD_N-1).
- COORD_W, 4, coordinate width; must satisfy 2**COORD_W > BOARD_N.

Ports:
- clk  in  1  25 MHz pixel clock; same net as VgaCtrl pclk.
- rst  in  1  asynchronous, active-low reset.
- btn_up / btn_down / btn_left / btn_right  in  1 each  single-cycle move pulses.
- btn_place  in  1  single-cycle place pulse.
- new_game  in  1  single-cycle pulse; clears board and restarts game.
- rd_x  in  COORD_W  read-port column from the renderer.
- rd_y  in  COORD_W  read-port row from the renderer.
- rd_cell  out  2  cell at (rd_x, rd_y), one cycle later.
- cursor_x  out  COORD_W  cursor column.
- cursor_y  out  COORD_W  cursor row.
- turn  out  1  side to move: 0 = black, 1 = white.
- busy  out  1  high while clearing or checking a placement.
- place_ok  out  1  one-cycle pulse when a stone is written.
- place_err  out  1  one-cycle pulse when a placement is rejected.
- stone_count  out  8  stones on board.
- board_full  out  1  stone_count == BOARD_N*BOARD_N.

Behaviour:
- Cell encoding: 00 EMPTY, 01 BLACK, 10 WHITE, 11 reserved (never written).
- Storage: BOARD_N*BOARD_N x 2-bit array, linear index y*BOARD_N + x.
  - One write port.
  - Two read ports: renderer, and internal check.
- Reset (rst low, async):
  - State CLEAR, clear index 0, busy=1.
  - cursor=(BOARD_N/2, BOARD_N/2) = (7,7); turn=0.
  - place_ok=0, place_err=0, rd_cell=00, stone_count=0.
- FSM states:
  - CLEAR:
    - Writes EMPTY at clear index each cycle; index increments.
    - After index BOARD_N*BOARD_N-1 (225 cycles total), goes to IDLE.
    - busy=1; all buttons ignored.
  - IDLE: busy=0; acts on inputs, in priority order:
    - new_game.
    - btn_place: latches the cursor index, goes to CHECK.
    - Moves.
  - CHECK: one cycle; the internal read of the latched index is valid.
    - Cell EMPTY: write stone (turn 0 -> BLACK, 1 -> WHITE), toggle turn, stone_count+1, place_ok pulse on the following cycle.
    - Cell not EMPTY: no write, place_err pulse on the following cycle.
    - Always returns to IDLE. busy=1; moves are dropped.
- new_game in any state (CLEAR, IDLE, CHECK):
  - Restarts CLEAR at index 0.
  - Resets cursor, turn and stone_count to their reset values.
  - Aborts a pending CHECK; no pulse is issued.
- Moves (IDLE only):
  - up: y-1; down: y+1; left: x-1; right: x+1.
  - up+down in the same cycle cancel; left+right likewise.
  - Different axes apply together.
  - Without CURSOR_WRAP_EN, moves saturate at 0 and BOARD_N-1.
- Read port:
  - rd_cell registered: one-cycle latency from rd_x/rd_y.
  - Returns 00 if rd_x >= BOARD_N, rd_y >= BOARD_N, or busy during CLEAR.
  - Reads do not depend on turn or FSM state otherwise.
  - A write in CHECK is visible on rd_cell from the cycle after the write.
- Full board: every place attempt produces place_err (no EMPTY cells); board_full=1.
- stone_count never exceeds 225; width is sufficient, no wrap.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: moves wrap; x=0 + left -> BOARD_N-1, x=BOARD_N-1 + right -> 0; same for y.
- Undefined: moves saturate at the edges as above.
- All other behaviour is identical.

Decomposition:
- Package gomoku_pkg:
  - Cell encoding constants (CELL_EMPTY, CELL_BLACK, CELL_WHITE).
  - FSM state encoding (ST_CLEAR, ST_IDLE, ST_CHECK).
  - BOARD_N default; board cell count constant.
  - Shared with pixel_gen.
- Sub-module cursor_ctrl:
  - Inputs: move pulses, enable, new_game.
  - Outputs: cursor_x, cursor_y.
  - Contains the saturate/wrap logic.

Test Plan:
- Release rst, hold buttons low -> busy=1 for exactly 225 cycles then 0; cursor=(7,7); turn=0; rd_cell=00 at any (x,y).
- After clear, btn_place once -> place_ok two cycles later; rd(7,7)=01; turn=1; stone_count=1. Second btn_place at (7,7) -> place_err; no state change.
- From (0,0): btn_left, then btn_up -> cursor stays (0,0) without macro; (14,14) with CURSOR_WRAP_EN. btn_left+btn_right same cycle -> x unchanged.
- btn_place then new_game on the next cycle (during CHECK) -> no place_ok/err pulse; busy=1 for 225 cycles; stone_count=0; rd(7,7)=00.
- Fill all 225 cells alternating turns -> board_full=1, stone_count=225; a further place -> place_err. rd_x=15 -> rd_cell=00.
- Assert rst low mid-CLEAR and mid-CHECK -> outputs immediately at reset values; full clear restarts on release.
